// File: rtl/csr_access_ctrl_pkg.sv
// csr_pkg: Zicsr funct3 encodings, access FSM states and the read-only CSR address field.
package csr_pkg;
   typedef enum logic [2:0] {
      CSR_RW  = 3'b001,
      CSR_RS  = 3'b010,
      CSR_RC  = 3'b011,
      CSR_RWI = 3'b101,
      CSR_RSI = 3'b110,
      CSR_RCI = 3'b111
   } csr_op_e;
   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      WAIT,
      RESP
   } csr_state_e;
   localparam int CSR_ADDR_W = 12;
   localparam logic [1:0] CSR_RO_FIELD = 2'b11;
   function automatic logic csr_is_ro(input logic [CSR_ADDR_W-1:0] addr);
      return addr[11:10] == CSR_RO_FIELD;
   endfunction
endpackage

// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: pipeline request/response and CSR unit signals of the CSR access controller.
interface csr_access_ctrl_if #(parameter int XLEN = 32);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_func3;
   logic [11:0]     req_addr;
   logic [XLEN-1:0] req_rs1;
   logic [4:0]      req_zimm;
   logic            req_rd_zero;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_illegal;
   logic [11:0]     csr_addr_o;
   logic [XLEN-1:0] csr_rdata_i;
   logic [XLEN-1:0] csr_wdata_o;
   logic            csr_we_o;
   logic            csr_done_i;
   modport master (
      output req_valid, req_func3, req_addr, req_rs1, req_zimm, req_rd_zero, rsp_ready,
             csr_rdata_i, csr_done_i,
      input  req_ready, rsp_valid, rsp_rdata, rsp_illegal, csr_addr_o, csr_wdata_o, csr_we_o
   );
   modport slave (
      input  req_valid, req_func3, req_addr, req_rs1, req_zimm, req_rd_zero, rsp_ready,
             csr_rdata_i, csr_done_i,
      output req_ready, rsp_valid, rsp_rdata, rsp_illegal, csr_addr_o, csr_wdata_o, csr_we_o
   );
endinterface

// File: rtl/csr_access_ctrl_alu.sv
// csr_alu: new CSR value from old value and rs1/zimm source, plus the RS/RC zero-source write suppress.
module csr_alu
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] old,
   input  logic [XLEN-1:0] rs1,
   input  logic [4:0]      zimm,
   input  logic [2:0]      func3,
   output logic [XLEN-1:0] new_val,
   output logic            write_suppress
);
   logic [XLEN-1:0] src;
   always_comb begin
      src = func3[2] ? XLEN'(zimm) : rs1;
      new_val = (func3[1:0] == CSR_RW[1:0]) ? src :
                (func3[1:0] == CSR_RS[1:0]) ? (old | src) : (old & ~src);
      write_suppress = func3[1] && (zimm == 5'd0);
   end
endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: runs one Zicsr instruction at a time against the CSR unit (read, modify, write, ack).
// Optional: CSR_ACCESS_TIMEOUT_EN bounds the wait for csr_done_i to TIMEOUT_CYCLES and flags illegal.
module csr_access_ctrl
   import csr_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic          clk,
   input logic          rst,
   csr_access_ctrl_if.slave bus
);
   csr_state_e      state;
   logic [2:0]      func3;
   logic [XLEN-1:0] rs1;
   logic [4:0]      zimm;
   logic [XLEN-1:0] new_val;
   logic            suppress;
   logic            illegal;
   logic            timed_out;

   if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   csr_alu #(.XLEN(XLEN)) u_alu (
      .old           (bus.csr_rdata_i),
      .rs1           (rs1),
      .zimm          (zimm),
      .func3         (func3),
      .new_val       (new_val),
      .write_suppress(suppress)
   );

   // funct3 x00 is not a Zicsr op; writes to the read-only address field trap
   assign illegal = (func3[1:0] == 2'b00) || (!suppress && csr_is_ro(bus.csr_addr_o));

`ifdef CSR_ACCESS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;
   assign timed_out = wait_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         func3           <= '0;
         rs1             <= '0;
         zimm            <= '0;
         bus.req_ready   <= 1'b1;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= '0;
         bus.rsp_illegal <= 1'b0;
         bus.csr_we_o    <= 1'b0;
         bus.csr_wdata_o <= '0;
         bus.csr_addr_o  <= '0;
`ifdef CSR_ACCESS_TIMEOUT_EN
         wait_cnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               state          <= READ;
               bus.req_ready  <= 1'b0;
               func3          <= bus.req_func3;
               rs1            <= bus.req_rs1;
               zimm           <= bus.req_zimm;
               bus.csr_addr_o <= bus.req_addr;
            end
            READ: begin
               bus.rsp_rdata   <= illegal ? '0 : bus.csr_rdata_i;
               bus.rsp_illegal <= illegal;
               if (illegal || suppress) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
               end else begin
                  state           <= WRITE;
                  bus.csr_we_o    <= 1'b1;
                  bus.csr_wdata_o <= new_val;
               end
            end
            WRITE: begin
               state        <= WAIT;
               bus.csr_we_o <= 1'b0;
`ifdef CSR_ACCESS_TIMEOUT_EN
               wait_cnt     <= '0;
`endif
            end
            WAIT: begin
`ifdef CSR_ACCESS_TIMEOUT_EN
               wait_cnt <= wait_cnt + 1'b1;
`endif
               if (bus.csr_done_i) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
               end else if (timed_out) begin
                  state           <= RESP;
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_illegal <= 1'b1;
                  bus.rsp_rdata   <= '0;
               end
            end
            RESP: if (bus.rsp_ready) begin
               state          <= IDLE;
               bus.rsp_valid  <= 1'b0;
               bus.req_ready  <= 1'b1;
               bus.csr_addr_o <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed Zicsr accesses against a CSR unit model, scoreboarded responses and writes.
module tb_csr_access_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          errors = 0;
   int          we_cnt = 0;
   logic [32:0] rsp_q[$];
   logic [43:0] wr_q[$];
   logic [31:0] csr_val = '0;
   logic        done_en = 1'b1;
   logic        we_prev = 1'b0;

   csr_access_ctrl_if #(.XLEN(32)) bus ();

   csr_access_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.csr_rdata_i = csr_val;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // CSR unit model: acknowledges a write one cycle after seeing it
   always @(negedge clk) begin
      bus.csr_done_i = we_prev & done_en;
      we_prev = bus.csr_we_o;
   end

   always @(negedge clk) begin
      #1;
      if (!rst && bus.csr_we_o) begin
         logic [43:0] w;
         we_cnt++;
         chk("write_expected", wr_q.size() != 0, 1);
         if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            chk("csr_addr_o", bus.csr_addr_o, w[43:32]);
            chk("csr_wdata_o", bus.csr_wdata_o, w[31:0]);
         end
      end
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         logic [32:0] r;
         chk("rsp_expected", rsp_q.size() != 0, 1);
         if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, r[32:1]);
            chk("rsp_illegal", bus.rsp_illegal, r[0]);
         end
      end
   end

   task automatic do_req(input string name, input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] rs1, input logic [4:0] z, input logic [31:0] old,
                         input logic ill, input logic we, input logic [31:0] wd,
                         input int lat_exp, input int stall);
      int lat = 0;
      @(negedge clk);
      for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
      chk({name, "_req_ready"}, bus.req_ready, 1);
      csr_val = old;
      we_cnt = 0;
      rsp_q.push_back({ill ? 32'h0 : old, ill});
      if (we) wr_q.push_back({a, wd});
      bus.req_valid = 1'b1;
      bus.req_func3 = f3;
      bus.req_addr = a;
      bus.req_rs1 = rs1;
      bus.req_zimm = z;
      bus.req_rd_zero = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr = 12'hFFF;
      bus.req_rs1 = '1;
      bus.req_zimm = 5'h1A;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.rsp_valid) break;
      end
      chk({name, "_latency"}, lat, lat_exp);
      for (int i = 0; i < stall; i++) begin
         chk({name, "_stall_valid"}, bus.rsp_valid, 1);
         chk({name, "_stall_rdata"}, bus.rsp_rdata, ill ? 32'h0 : old);
         chk({name, "_stall_req_ready"}, bus.req_ready, 0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({name, "_we_pulses"}, we_cnt, {31'd0, we});
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_req_ready"}, bus.req_ready, 1);
      chk({name, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({name, "_rsp_rdata"}, bus.rsp_rdata, 0);
      chk({name, "_rsp_illegal"}, bus.rsp_illegal, 0);
      chk({name, "_csr_we_o"}, bus.csr_we_o, 0);
      chk({name, "_csr_wdata_o"}, bus.csr_wdata_o, 0);
      chk({name, "_csr_addr_o"}, bus.csr_addr_o, 0);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_func3 = '0;
      bus.req_addr = '0;
      bus.req_rs1 = '0;
      bus.req_zimm = '0;
      bus.req_rd_zero = 1'b0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      do_req("csrrw",        3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 32'h12,       0, 1, 32'hDEADBEEF, 4, 0);
      do_req("csrrs",        3'b010, 12'h300, 32'h8,        5'd2, 32'h1,        0, 1, 32'h9,        4, 0);
      do_req("csrrci",       3'b111, 12'h304, 32'hFFFF0000, 5'h3, 32'hF,        0, 1, 32'hC,        4, 0);
      do_req("csrrs_ro_x0",  3'b010, 12'hC00, 32'h8,        5'd0, 32'hABCD,     0, 0, 32'h0,        2, 0);
      do_req("csrrw_ro",     3'b001, 12'hC00, 32'h5,        5'd3, 32'h77,       1, 0, 32'h0,        2, 0);
      do_req("csrrwi_ro_z0", 3'b101, 12'hC01, 32'h0,        5'd0, 32'h77,       1, 0, 32'h0,        2, 0);
      do_req("f3_100",       3'b100, 12'h300, 32'h1,        5'd1, 32'h33,       1, 0, 32'h0,        2, 0);
      do_req("f3_000",       3'b000, 12'h300, 32'h1,        5'd1, 32'h33,       1, 0, 32'h0,        2, 0);
      do_req("csrrsi_z0",    3'b110, 12'h341, 32'hFFFF,     5'd0, 32'h55,       0, 0, 32'h0,        2, 0);
      do_req("csrrwi",       3'b101, 12'h305, 32'hFFFFFFFF, 5'h1F, 32'h0,       0, 1, 32'h1F,       4, 0);
      do_req("csrrc",        3'b011, 12'hBFF, 32'hF0,       5'd7, 32'hFFFFFFFF, 0, 1, 32'hFFFFFF0F, 4, 0);
      bus.rsp_ready = 1'b0;
      do_req("stall",        3'b010, 12'h300, 32'h10,       5'd4, 32'h3,        0, 1, 32'h13,       4, 5);
      // reset while the write is waiting for an acknowledge that never comes
      done_en = 1'b0;
      @(negedge clk);
      csr_val = 32'h99;
      wr_q.push_back({12'h340, 32'hCAFE});
      bus.req_valid = 1'b1;
      bus.req_func3 = 3'b001;
      bus.req_addr = 12'h340;
      bus.req_rs1 = 32'hCAFE;
      bus.req_zimm = 5'd1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("wait_addr_held", bus.csr_addr_o, 12'h340);
      chk("wait_req_ready", bus.req_ready, 0);
      chk("wait_rsp_valid", bus.rsp_valid, 0);
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst_in_wait");
      @(negedge clk);
      rst = 1'b0;
      done_en = 1'b1;
      do_req("after_rst",    3'b001, 12'h340, 32'h1234,     5'd1, 32'hCAFE,     0, 1, 32'h1234,     4, 0);
`ifdef CSR_ACCESS_TIMEOUT_EN
      done_en = 1'b0;
      do_req("timeout",      3'b001, 12'h340, 32'h5,        5'd1, 32'h66,       1, 1, 32'h5,       19, 0);
      done_en = 1'b1;
`endif
      chk("rsp_q_drained", rsp_q.size(), 0);
      chk("wr_q_drained", wr_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, expected to end earlier");
      $fatal(1, "watchdog expired");
   end
endmodule
